// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder and its RAM array.
package data_mem_responder_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } memstate_e;

  localparam int MEM_WORD_BYTES = 4;

  // Replace the byte lanes of oldWord selected by be with the matching lanes of newWord.
  function automatic word_t mergeBytes(input word_t oldWord, input word_t newWord, input byte_en_t be);
    word_t merged;
    merged = oldWord;
    for (int i = 0; i < MEM_WORD_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = newWord[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store port between the Memory-Access stage (master) and the responder (slave).
interface data_mem_responder_if;
  import data_mem_responder_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  word_t       req_wdata;
  byte_en_t    req_be;
  logic        resp_valid;
  word_t       resp_rdata;
  logic        resp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );

endinterface

// File: rtl/data_mem_responder_mem_array.sv
// Word-organised single-port RAM: per-byte synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AddrW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  byte_en_t         wrEn,
  input  logic [AddrW-1:0] addr,
  input  word_t            wrData,
  output word_t            rdData
);

  word_t mem [DEPTH];

  // Commit each enabled byte lane at the clock edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < MEM_WORD_BYTES; i++) begin
      if (wrEn[i]) mem[addr][8*i +: 8] <= wrData[8*i +: 8];
    end
  end

  assign rdData = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's load/store port. One request in flight,
// fixed access latency, store commit / load sample at the edge entering RESP.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int AddrW = $clog2(DEPTH);
  localparam int CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  memstate_e       state, nextState;
  logic [CntW-1:0] cnt, cntNext;

  logic        reqReady;
  logic        acceptNow;
  logic        enterResp;

  logic        weQ;
  logic [31:0] addrQ;
  word_t       wdataQ;
  byte_en_t    beQ;

  logic        curWe;
  logic [31:0] curAddr;
  word_t       curWdata;
  byte_en_t    curBe;
  logic        curErr;

  byte_en_t    ramWrEn;
  word_t       ramRdata;
  word_t       respData;

  word_t       rdataQ;
  logic        errQ;

  assign reqReady = (state != MEM_WAIT);
  assign acceptNow = bus.req_valid && reqReady;

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = (state == MEM_RESP);
  assign bus.resp_rdata = rdataQ;
  assign bus.resp_err   = errQ;
  assign bus.busy       = (state != MEM_IDLE);

  // State and latency counter register; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MEM_IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= cntNext;
    end
  end

  // Next-state logic: RESP doubles as an accept slot so back-to-back requests keep the pipe full.
  always_comb begin
    nextState = state;
    cntNext   = cnt;
    unique case (state)
      MEM_IDLE, MEM_RESP: begin
        if (acceptNow) begin
          if (LATENCY == 1) begin
            nextState = MEM_RESP;
          end else begin
            nextState = MEM_WAIT;
            cntNext   = CntW'(LATENCY - 1);
          end
        end else begin
          nextState = MEM_IDLE;
        end
      end
      MEM_WAIT: begin
        cntNext = cnt - CntW'(1);
        if (cnt == CntW'(1)) nextState = MEM_RESP;
      end
      default: begin
        nextState = MEM_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // With single-cycle latency the request enters RESP on the very edge it is accepted,
  // so the live inputs must be used instead of the latched copy.
  always_comb begin
    if (acceptNow) begin
      curWe    = bus.req_we;
      curAddr  = bus.req_addr;
      curWdata = bus.req_wdata;
      curBe    = bus.req_be;
    end else begin
      curWe    = weQ;
      curAddr  = addrQ;
      curWdata = wdataQ;
      curBe    = beQ;
    end

    curErr    = (curAddr[1:0] != 2'b00) || (32'(curAddr[31:2]) >= 32'(DEPTH));
    enterResp = (nextState == MEM_RESP) && !reset;

    ramWrEn = '0;
    if (enterResp && curWe && !curErr) ramWrEn = curBe;

    if (curErr)     respData = '0;
    else if (curWe) respData = mergeBytes(ramRdata, curWdata, curBe);
    else            respData = ramRdata;
  end

  // Capture the request on accept and the response word/error on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      beQ    <= '0;
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      if (acceptNow) begin
        weQ    <= bus.req_we;
        addrQ  <= bus.req_addr;
        wdataQ <= bus.req_wdata;
        beQ    <= bus.req_be;
      end
      if (enterResp) begin
        rdataQ <= respData;
        errQ   <= curErr;
      end
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .AddrW (AddrW)
  ) uMemArray (
    .clk    (clk),
    .wrEn   (ramWrEn),
    .addr   (curAddr[AddrW+1:2]),
    .wrData (curWdata),
    .rdData (ramRdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=2, one at LATENCY=1.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int Depth = 32;
  localparam int LatA  = 2;
  localparam int LatB  = 1;
  localparam int Guard = 40;

  typedef struct {
    word_t rdata;
    logic  err;
    int    due;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  int    cycle = 0;
  int    compared = 0;
  int    mismatched = 0;
  exp_t  expA[$];
  exp_t  expB[$];
  word_t modelMem [2][Depth];

  data_mem_responder_if ifA ();
  data_mem_responder_if ifB ();

  data_mem_responder #(.DEPTH(Depth), .LATENCY(LatA)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (ifA)
  );

  data_mem_responder #(.DEPTH(Depth), .LATENCY(LatB)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (ifB)
  );

  // Free-running clock and cycle count used to time responses.
  always #5 clk = ~clk;

  // Cycle N is the interval after the N-th rising edge.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, actual, required, cycle);
    end
  endtask

  task automatic driveReq(input int idx, input logic v, input logic we, input logic [31:0] addr,
                          input word_t wdata, input byte_en_t be);
    if (idx == 0) begin
      ifA.req_valid = v; ifA.req_we = we; ifA.req_addr = addr; ifA.req_wdata = wdata; ifA.req_be = be;
    end else begin
      ifB.req_valid = v; ifB.req_we = we; ifB.req_addr = addr; ifB.req_wdata = wdata; ifB.req_be = be;
    end
  endtask

  function automatic logic readyOf(input int idx);
    return (idx == 0) ? ifA.req_ready : ifB.req_ready;
  endfunction

  // Reference model: memory is a plain array updated in acceptance order.
  function automatic exp_t modelAccess(input int idx, input logic we, input logic [31:0] addr,
                                       input word_t wdata, input byte_en_t be, input int acceptCycle);
    exp_t  x;
    word_t mask;
    int    wordIdx;
    x.due   = acceptCycle + ((idx == 0) ? LatA : LatB);
    x.err   = ((addr % 4) != 0) || ((addr / 4) >= Depth);
    x.rdata = '0;
    if (!x.err) begin
      wordIdx = int'(addr / 4);
      if (we) begin
        mask = '0;
        for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
        modelMem[idx][wordIdx] = (modelMem[idx][wordIdx] & ~mask) | (wdata & mask);
      end
      x.rdata = modelMem[idx][wordIdx];
    end
    return x;
  endfunction

  // Called at a falling edge: present the request, wait for ready, record expectation.
  task automatic applyStimulus(input int idx, input logic we, input logic [31:0] addr,
                               input word_t wdata, input byte_en_t be, output int acceptCycle);
    int   guard = 0;
    exp_t x;
    driveReq(idx, 1'b1, we, addr, wdata, be);
    while (!readyOf(idx) && guard < Guard) begin
      @(negedge clk);
      guard++;
    end
    acceptCycle = cycle;
    if (guard >= Guard) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL acceptTimeout: req_ready stuck low on port %0d", idx);
    end else begin
      x = modelAccess(idx, we, addr, wdata, be, acceptCycle);
      if (idx == 0) expA.push_back(x);
      else          expB.push_back(x);
    end
    @(negedge clk);
    driveReq(idx, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic monitorOne(input int idx, input logic v, input word_t rd, input logic e);
    exp_t x;
    int   n;
    n = (idx == 0) ? expA.size() : expB.size();
    if (n > 0) begin
      if (idx == 0) x = expA[0];
      else          x = expB[0];
    end
    if (v) begin
      if (n == 0) begin
        checkOutput($sformatf("unexpectedResp%0d", idx), 32'(v), 32'd0);
      end else begin
        if (idx == 0) void'(expA.pop_front());
        else          void'(expB.pop_front());
        checkOutput($sformatf("respCycle%0d", idx), 32'(cycle), 32'(x.due));
        checkOutput($sformatf("respRdata%0d", idx), rd, x.rdata);
        checkOutput($sformatf("respErr%0d", idx), 32'(e), 32'(x.err));
      end
    end else if (n > 0 && x.due <= cycle) begin
      checkOutput($sformatf("missingResp%0d", idx), 32'(v), 32'd1);
      if (idx == 0) void'(expA.pop_front());
      else          void'(expB.pop_front());
    end
  endtask

  // Monitor: compare every response pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      monitorOne(0, ifA.resp_valid, ifA.resp_rdata, ifA.resp_err);
      monitorOne(1, ifB.resp_valid, ifB.resp_rdata, ifB.resp_err);
    end
  end

  task automatic checkResetOutputs(input int idx, input string tag);
    if (idx == 0) begin
      checkOutput({tag, "RespValidA"}, 32'(ifA.resp_valid), 32'd0);
      checkOutput({tag, "ReqReadyA"},  32'(ifA.req_ready),  32'd1);
      checkOutput({tag, "BusyA"},      32'(ifA.busy),       32'd0);
      checkOutput({tag, "RdataA"},     ifA.resp_rdata,      32'd0);
      checkOutput({tag, "ErrA"},       32'(ifA.resp_err),   32'd0);
    end else begin
      checkOutput({tag, "RespValidB"}, 32'(ifB.resp_valid), 32'd0);
      checkOutput({tag, "ReqReadyB"},  32'(ifB.req_ready),  32'd1);
      checkOutput({tag, "BusyB"},      32'(ifB.busy),       32'd0);
      checkOutput({tag, "RdataB"},     ifB.resp_rdata,      32'd0);
      checkOutput({tag, "ErrB"},       32'(ifB.resp_err),   32'd0);
    end
  endtask

  task automatic waitDrain();
    int guard = 0;
    while ((expA.size() != 0 || expB.size() != 0) && guard < Guard) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= Guard) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drainTimeout: %0d/%0d responses outstanding", expA.size(), expB.size());
    end
    @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic on both instances.
  initial begin
    int          acc;
    int          accs[4];
    logic        we;
    logic [31:0] addr;

    driveReq(0, 1'b0, 1'b0, '0, '0, '0);
    driveReq(1, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkResetOutputs(0, "powerOn");
    checkResetOutputs(1, "powerOn");

    $display("[TB] filling both memories with known data");
    for (int w = 0; w < Depth; w++) applyStimulus(0, 1'b1, 32'(w * 4), $urandom, 4'hF, acc);
    for (int w = 0; w < Depth; w++) applyStimulus(1, 1'b1, 32'(w * 4), $urandom, 4'hF, acc);
    waitDrain();

    $display("[TB] full-word store/load, partial store, error cases");
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, acc);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, acc);
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, acc);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, acc);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, acc);
    applyStimulus(0, 1'b0, 32'h22, 32'h0, 4'h0, acc);
    applyStimulus(0, 1'b0, 32'(Depth * 4), 32'h0, 4'h0, acc);
    applyStimulus(0, 1'b1, 32'h22, 32'hFFFFFFFF, 4'hF, acc);
    applyStimulus(0, 1'b1, 32'(Depth * 4), 32'hFFFFFFFF, 4'hF, acc);
    applyStimulus(0, 1'b1, 32'h10, 32'h0, 4'b0000, acc);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, acc);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, acc);
    waitDrain();

    $display("[TB] back-to-back loads");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, accs[i]);
      checkOutput($sformatf("readyInWait%0d", i), 32'(ifA.req_ready), 32'd0);
      checkOutput($sformatf("busyInWait%0d", i), 32'(ifA.busy), 32'd1);
    end
    for (int i = 1; i < 4; i++) checkOutput($sformatf("acceptSpacing%0d", i), 32'(accs[i] - accs[i-1]), 32'(LatA));
    waitDrain();

    $display("[TB] reset during an in-flight store");
    applyStimulus(0, 1'b1, 32'h30, 32'h5555AAAA, 4'hF, acc);
    waitDrain();
    driveReq(0, 1'b1, 1'b1, 32'h30, 32'h12345678, 4'hF);
    @(negedge clk);
    checkOutput("busyBeforeAbort", 32'(ifA.busy), 32'd1);
    driveReq(0, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetOutputs(0, "afterAbort");
    repeat (3) @(negedge clk);
    applyStimulus(0, 1'b0, 32'h30, 32'h0, 4'h0, acc);
    waitDrain();

    $display("[TB] single-cycle latency store then load");
    applyStimulus(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, accs[0]);
    applyStimulus(1, 1'b0, 32'h40, 32'h0, 4'h0, accs[1]);
    checkOutput("lat1Spacing", 32'(accs[1] - accs[0]), 32'(LatB));
    waitDrain();

    $display("[TB] randomized traffic");
    for (int idx = 0; idx < 2; idx++) begin
      for (int n = 0; n < 150; n++) begin
        we   = 1'($urandom_range(0, 1));
        addr = 32'($urandom_range(0, Depth + 1)) * 4;
        if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 3));
        applyStimulus(idx, we, addr, $urandom, 4'($urandom_range(0, 15)), acc);
        if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      waitDrain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
